// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, controller states, latched
// request record and the LOAD_MODE word builder.
package sdram_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF, INIT_MODE, IDLE,
    ACT, RW, RD_DATA, RECOVER, REFRESH
  } state_t;

  // {cs, ras, cas, we}, all active-low on the pins
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOADMODE  = 4'b0000;

  typedef struct packed {
    logic        we;
    logic [1:0]  ba;
    logic [7:0]  col;
    logic        half;
    logic [15:0] din;
    logic [1:0]  ds;
  } acc_req_t;

  // Single-location writes (A9), sequential bursts, CAS in A6:4, BL code in A2:0
  function automatic logic [10:0] mode_word(input int cas_lat, input int burst_len);
    logic [2:0] bl_code;
    bl_code = (burst_len == 4) ? 3'd2 : (burst_len == 2) ? 3'd1 : 3'd0;
    return {1'b0, 1'b1, 2'b00, 3'(cas_lat), 1'b0, bl_code};
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer with a saturating 2-deep pending count.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [1:0] o_pending
);
  localparam int TW = $clog2(REF_INTERVAL + 1);

  logic [TW-1:0] r_tmr;
  logic [1:0]    r_pend;
  logic          w_expire;

  assign w_expire  = i_en && (r_tmr == TW'(REF_INTERVAL - 1));
  assign o_pending = r_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr  <= '0;
      r_pend <= 2'd0;
    end else begin
      if (!i_en || w_expire) r_tmr <= '0;
      else                   r_tmr <= r_tmr + 1'b1;
      // simultaneous expiry and service leaves the count unchanged
      case ({w_expire, i_clr})
        2'b10:   if (r_pend != 2'd2) r_pend <= r_pend + 2'd1;
        2'b01:   if (r_pend != 2'd0) r_pend <= r_pend - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_burst_ctrl.sv
// Single-port SDRAM controller: power-up init, periodic auto-refresh,
// auto-precharged single writes and short read bursts on a 16-bit host port.
module sdram_burst_ctrl
  import sdram_pkg::*;
#(
  parameter int CAS_LAT      = 2,
  parameter int T_RCD        = 1,
  parameter int T_RP         = 1,
  parameter int T_RFC        = 3,
  parameter int BURST_LEN    = 1,
  parameter int REF_INTERVAL = 250,
  parameter int INIT_CYCLES  = 3200
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  input  logic        req,
  input  logic        we,
  input  logic [21:0] addr,
  input  logic [15:0] din,
  input  logic [1:0]  ds,
  output logic        ack,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        sd_clk,
  output logic        sd_cke,
  inout  logic [31:0] sd_data,
  output logic [10:0] sd_addr,
  output logic [1:0]  sd_ba,
  output logic [3:0]  sd_dqm,
  output logic        sd_cs,
  output logic        sd_ras,
  output logic        sd_cas,
  output logic        sd_we
);
  localparam logic [15:0] C_INIT  = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] C_RP    = 16'(T_RP - 1);
  localparam logic [15:0] C_RFC   = 16'(T_RFC - 1);
  localparam logic [15:0] C_RFC2  = 16'(2 * T_RFC - 1);
  localparam logic [15:0] C_RCD   = 16'(T_RCD - 1);
  localparam logic [15:0] C_CAS   = 16'(CAS_LAT - 1);
  localparam logic [15:0] C_RDEND = 16'(CAS_LAT + BURST_LEN - 2);
  localparam logic [10:0] MODE    = mode_word(CAS_LAT, BURST_LEN);

  state_t      r_state, w_state;
  logic [15:0] r_cnt;
  logic        w_cnt_clr;
  acc_req_t    r_req;
  logic        w_latch;
  logic [3:0]  r_cmd, w_cmd;
  logic [10:0] r_sd_addr, w_sd_addr;
  logic [1:0]  r_sd_ba, w_sd_ba;
  logic [3:0]  r_dqm, w_dqm;
  logic        r_oe, w_oe;
  logic [31:0] r_dq;
  logic        r_ack, w_ack;
  logic        r_ready;
  logic [15:0] r_dout;
  logic        r_dout_valid, w_cap;
  logic        w_ref_clr;
  logic [1:0]  w_ref_pend;

  sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_ready),
    .i_clr     (w_ref_clr),
    .o_pending (w_ref_pend)
  );

  assign sd_clk  = clk;
  assign sd_cke  = 1'b1;
  assign {sd_cs, sd_ras, sd_cas, sd_we} = r_cmd;
  assign sd_addr = r_sd_addr;
  assign sd_ba   = r_sd_ba;
  assign sd_dqm  = r_dqm;
  assign sd_data = r_oe ? r_dq : 32'bz;
  assign ready      = r_ready;
  assign ack        = r_ack;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

  always_comb begin
    w_state   = r_state;
    w_cnt_clr = 1'b0;
    w_cmd     = CMD_NOP;
    w_sd_addr = r_sd_addr;
    w_sd_ba   = r_sd_ba;
    w_dqm     = 4'b0000;
    w_oe      = 1'b0;
    w_ack     = 1'b0;
    w_latch   = 1'b0;
    w_ref_clr = 1'b0;
    w_cap     = 1'b0;
    case (r_state)
      INIT_WAIT: begin
        w_cmd = CMD_INHIBIT;
        if (r_cnt == C_INIT) begin
          w_state = INIT_PRE; w_cnt_clr = 1'b1;
          w_cmd = CMD_PRECHARGE; w_sd_addr = 11'h400;
        end
      end
      INIT_PRE: if (r_cnt == C_RP) begin
        w_state = INIT_REF; w_cnt_clr = 1'b1; w_cmd = CMD_REFRESH;
      end
      INIT_REF: begin
        if (r_cnt == C_RFC) w_cmd = CMD_REFRESH;
        else if (r_cnt == C_RFC2) begin
          w_state = INIT_MODE; w_cnt_clr = 1'b1;
          w_cmd = CMD_LOADMODE; w_sd_addr = MODE; w_sd_ba = 2'b00;
        end
      end
      INIT_MODE: if (r_cnt == 16'd1) begin
        w_state = IDLE; w_cnt_clr = 1'b1;
      end
      IDLE: begin
        // refresh always wins over a request seen in the same cycle
        if (w_ref_pend != 2'd0) begin
          w_state = REFRESH; w_cnt_clr = 1'b1; w_cmd = CMD_REFRESH; w_ref_clr = 1'b1;
        end else if (req) begin
          w_state = ACT; w_cnt_clr = 1'b1; w_latch = 1'b1;
          w_cmd = CMD_ACTIVE; w_sd_addr = addr[19:9]; w_sd_ba = addr[21:20];
        end
      end
      ACT: if (r_cnt == C_RCD) begin
        w_state   = RW; w_cnt_clr = 1'b1;
        w_cmd     = r_req.we ? CMD_WRITE : CMD_READ;
        w_sd_addr = {1'b1, 2'b00, r_req.col};
        w_sd_ba   = r_req.ba;
        if (r_req.we) begin
          w_oe  = 1'b1;
          w_dqm = r_req.half ? {2'b11, r_req.ds} : {r_req.ds, 2'b11};
        end
      end
      RW: begin
        w_state = r_req.we ? RECOVER : RD_DATA; w_cnt_clr = 1'b1;
      end
      RD_DATA: begin
        w_cap = (r_cnt >= C_CAS);
        if (r_cnt == C_RDEND) begin
          w_state = RECOVER; w_cnt_clr = 1'b1;
        end
      end
      RECOVER: if (r_cnt == C_RP) begin
        w_state = IDLE; w_cnt_clr = 1'b1; w_ack = 1'b1;
      end
      REFRESH: if (r_cnt == C_RFC) begin
        w_state = IDLE; w_cnt_clr = 1'b1;
      end
      default: w_state = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= INIT_WAIT;
      r_cnt        <= '0;
      r_req        <= '0;
      r_cmd        <= CMD_INHIBIT;
      r_sd_addr    <= '0;
      r_sd_ba      <= '0;
      r_dqm        <= '0;
      r_oe         <= 1'b0;
      r_dq         <= '0;
      r_ack        <= 1'b0;
      r_ready      <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
      r_cmd        <= w_cmd;
      r_sd_addr    <= w_sd_addr;
      r_sd_ba      <= w_sd_ba;
      r_dqm        <= w_dqm;
      r_oe         <= w_oe;
      r_dq         <= {r_req.din, r_req.din};
      r_ack        <= w_ack;
      r_dout_valid <= w_cap;
      if (w_state == IDLE) r_ready <= 1'b1;
      if (w_cap) r_dout <= r_req.half ? sd_data[15:0] : sd_data[31:16];
      if (w_latch) begin
        r_req.we   <= we;
        r_req.ba   <= addr[21:20];
        r_req.col  <= addr[8:1];
        r_req.half <= addr[0];
        r_req.din  <= din;
        r_req.ds   <= ds;
      end
    end
  end

endmodule
